// File: rtl/trans_pkg.sv
// Shared constants and helpers for the BCD to Excess-3 converter.
// Optional feature macro used by the design: TRANS_ERR_EN (illegal-digit flagging).
package trans_pkg;

  localparam int         BCD_W       = 4;
  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] EX3_ILLEGAL = 4'b0000;

  // True for a legal BCD digit (0..9).
  function automatic logic bcd_digit_ok(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/trans_digit.sv
// Single-digit combinational BCD to Excess-3 converter.
// With TRANS_ERR_EN defined, digits above 9 map to the illegal Ex3 marker
// and raise bad_o; otherwise they wrap modulo 16 like any other digit.
module trans_digit
  import trans_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
`ifdef TRANS_ERR_EN
  output logic             bad_o,
`endif
  output logic [BCD_W-1:0] ex3_o
);

  logic [BCD_W-1:0] sum_w;

  assign sum_w = bcd_i + EX3_OFFSET;

`ifdef TRANS_ERR_EN
  // Flag illegal digits and replace their code with the illegal marker.
  always_comb begin
    bad_o = !bcd_digit_ok(bcd_i);
    ex3_o = bad_o ? EX3_ILLEGAL : sum_w;
  end
`else
  // Plain modulo-16 offset; illegal digits are not distinguished.
  always_comb begin
    ex3_o = sum_w;
  end
`endif

endmodule

// File: rtl/bcd_ex3_trans.sv
// Registered multi-digit BCD to Excess-3 converter with valid qualification.
// One result per accepted word, latency one cycle, no backpressure.
// Optional feature macro: TRANS_ERR_EN adds the err output and illegal-digit marking.
module bcd_ex3_trans
  import trans_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    out_valid,
`ifdef TRANS_ERR_EN
  output logic                    err,
`endif
  output logic [BCD_W*DIGITS-1:0] ex3
);

  logic [BCD_W*DIGITS-1:0] conv_w;
  logic [BCD_W*DIGITS-1:0] ex3_q, ex3_d;
  logic                    vld_q, vld_d;
`ifdef TRANS_ERR_EN
  logic [DIGITS-1:0]       bad_w;
  logic                    err_q, err_d;
`endif

  // Digits are converted independently; there is no inter-digit carry.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    trans_digit u_digit (
      .bcd_i (bcd[BCD_W*g +: BCD_W]),
`ifdef TRANS_ERR_EN
      .bad_o (bad_w[g]),
`endif
      .ex3_o (conv_w[BCD_W*g +: BCD_W])
    );
  end

  // Capture a new result on accepted words; otherwise hold data, drop valid.
  always_comb begin
    vld_d = in_valid;
    ex3_d = ex3_q;
`ifdef TRANS_ERR_EN
    err_d = err_q;
`endif
    if (in_valid) begin
      ex3_d = conv_w;
`ifdef TRANS_ERR_EN
      err_d = |bad_w;
`endif
    end
  end

  // Output registers with synchronous active-low reset; reset beats in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ex3_q <= '0;
`ifdef TRANS_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      ex3_q <= ex3_d;
`ifdef TRANS_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign ex3       = ex3_q;
`ifdef TRANS_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_bcd_ex3_trans.sv
// Self-checking bench for bcd_ex3_trans: a one-digit and a two-digit instance,
// expected results queued at drive time and compared when the output appears.
module tb_bcd_ex3_trans;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid1, in_valid2;
  logic [3:0] bcd1;
  logic [7:0] bcd2;
  logic       out_valid1, out_valid2;
  logic [3:0] ex3_1;
  logic [7:0] ex3_2;
  logic       err1, err2;

  int total = 0;
  int bad   = 0;

  // {err, ex3}
  logic [4:0] q1[$];
  logic [8:0] q2[$];
  logic [4:0] exp1;
  logic [8:0] exp2;
  logic [4:0] last1;

  always #5 clk = ~clk;

  bcd_ex3_trans #(.DIGITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .bcd       (bcd1),
    .out_valid (out_valid1),
`ifdef TRANS_ERR_EN
    .err       (err1),
`endif
    .ex3       (ex3_1)
  );

  bcd_ex3_trans #(.DIGITS(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .bcd       (bcd2),
    .out_valid (out_valid2),
`ifdef TRANS_ERR_EN
    .err       (err2),
`endif
    .ex3       (ex3_2)
  );

`ifndef TRANS_ERR_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  function automatic logic [4:0] model_digit(input logic [3:0] d);
    int v;
`ifdef TRANS_ERR_EN
    if (d > 9) return {1'b1, 4'b0000};
`endif
    v = (int'(d) + 3) % 16;
    return {1'b0, 4'(v)};
  endfunction

  function automatic logic [8:0] model_word(input logic [7:0] w);
    logic [4:0] lo, hi;
    lo = model_digit(w[3:0]);
    hi = model_digit(w[7:4]);
    return {lo[4] | hi[4], hi[3:0], lo[3:0]};
  endfunction

  // Drive one cycle on both instances; queue expectations for accepted words.
  task automatic cycle(input logic rst, input logic v1, input logic [3:0] b1,
                       input logic v2, input logic [7:0] b2);
    rst_n = rst; in_valid1 = v1; bcd1 = b1; in_valid2 = v2; bcd2 = b2;
    if (rst && v1) q1.push_back(model_digit(b1));
    if (rst && v2) q2.push_back(model_word(b2));
    @(posedge clk);
    #1;
    if (!rst) begin
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 4'd5, 1'b1, 8'h55);
      total++;
      if (out_valid1 !== 1'b0 || ex3_1 !== 4'd0 || err1 !== 1'b0) begin
        bad++;
        $display("FAIL reset1 cyc%0d: got v=%b ex3=%h err=%b want v=0 ex3=0 err=0", i, out_valid1, ex3_1, err1);
      end
      total++;
      if (out_valid2 !== 1'b0 || ex3_2 !== 8'd0 || err2 !== 1'b0) begin
        bad++;
        $display("FAIL reset2 cyc%0d: got v=%b ex3=%h err=%b want v=0 ex3=0 err=0", i, out_valid2, ex3_2, err2);
      end
    end
    last1 = 5'd0;
  endtask

  task automatic test_sweep();
    for (int d = 0; d < 10; d++) begin
      cycle(1'b1, 1'b1, 4'(d), 1'b0, 8'h00);
      exp1 = q1.pop_front();
      total++;
      if (out_valid1 !== 1'b1 || ex3_1 !== exp1[3:0] || err1 !== exp1[4] || ex3_1 !== 4'(d + 3)) begin
        bad++;
        $display("FAIL sweep d=%0d: got v=%b ex3=%h err=%b want v=1 ex3=%h err=%b", d, out_valid1, ex3_1, err1, exp1[3:0], exp1[4]);
      end
      last1 = exp1;
    end
  endtask

  task automatic test_invalid();
    for (int d = 10; d < 16; d++) begin
      cycle(1'b1, 1'b1, 4'(d), 1'b0, 8'h00);
      exp1 = q1.pop_front();
      total++;
      if (out_valid1 !== 1'b1 || ex3_1 !== exp1[3:0] || err1 !== exp1[4]) begin
        bad++;
        $display("FAIL invalid d=%0d: got v=%b ex3=%h err=%b want v=1 ex3=%h err=%b", d, out_valid1, ex3_1, err1, exp1[3:0], exp1[4]);
      end
      last1 = exp1;
    end
  endtask

  task automatic test_two_digit();
    logic [7:0] words[4];
    words[0] = 8'h47; words[1] = 8'h99; words[2] = 8'h9A; words[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 4'd0, 1'b1, words[i]);
      exp2 = q2.pop_front();
      total++;
      if (out_valid2 !== 1'b1 || ex3_2 !== exp2[7:0] || err2 !== exp2[8]) begin
        bad++;
        $display("FAIL two_digit bcd=%h: got v=%b ex3=%h err=%b want v=1 ex3=%h err=%b", words[i], out_valid2, ex3_2, err2, exp2[7:0], exp2[8]);
      end
    end
    total++;
    if (out_valid1 !== 1'b0 || ex3_1 !== last1[3:0]) begin
      bad++;
      $display("FAIL idle1 hold: got v=%b ex3=%h want v=0 ex3=%h", out_valid1, ex3_1, last1[3:0]);
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 1'b1, 4'd2, 1'b0, 8'h00);
    exp1 = q1.pop_front();
    total++;
    if (out_valid1 !== 1'b1 || ex3_1 !== 4'b0101) begin
      bad++;
      $display("FAIL hold load: got v=%b ex3=%h want v=1 ex3=5", out_valid1, ex3_1);
    end
    last1 = exp1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 4'd7, 1'b0, 8'h00);
      total++;
      if (out_valid1 !== 1'b0 || ex3_1 !== last1[3:0] || err1 !== last1[4]) begin
        bad++;
        $display("FAIL hold cyc%0d: got v=%b ex3=%h err=%b want v=0 ex3=%h err=%b", i, out_valid1, ex3_1, err1, last1[3:0], last1[4]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, 1'b1, 4'd1, 1'b0, 8'h00);
    exp1 = q1.pop_front();
    total++;
    if (out_valid1 !== 1'b1 || ex3_1 !== exp1[3:0]) begin
      bad++;
      $display("FAIL midrst first: got v=%b ex3=%h want v=1 ex3=%h", out_valid1, ex3_1, exp1[3:0]);
    end
    cycle(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    total++;
    if (out_valid1 !== 1'b0 || ex3_1 !== 4'd0 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL midrst cleared: got v=%b ex3=%h err=%b want v=0 ex3=0 err=0", out_valid1, ex3_1, err1);
    end
    cycle(1'b1, 1'b1, 4'd3, 1'b0, 8'h00);
    exp1 = q1.pop_front();
    total++;
    if (out_valid1 !== 1'b1 || ex3_1 !== 4'b0110 || ex3_1 !== exp1[3:0]) begin
      bad++;
      $display("FAIL midrst release: got v=%b ex3=%h want v=1 ex3=6", out_valid1, ex3_1);
    end
    last1 = exp1;
  endtask

  task automatic test_back_to_back();
    logic       v1, v2;
    logic [3:0] b1;
    logic [7:0] b2;
    for (int i = 0; i < 40; i++) begin
      v1 = ($urandom_range(0, 3) != 0);
      v2 = ($urandom_range(0, 3) != 0);
      b1 = 4'($urandom_range(0, 15));
      b2 = 8'($urandom_range(0, 255));
      cycle(1'b1, v1, b1, v2, b2);
      if (v1) begin
        exp1 = q1.pop_front();
        last1 = exp1;
      end
      total++;
      if (out_valid1 !== v1 || ex3_1 !== last1[3:0] || err1 !== last1[4]) begin
        bad++;
        $display("FAIL b2b1 i=%0d: got v=%b ex3=%h err=%b want v=%b ex3=%h err=%b", i, out_valid1, ex3_1, err1, v1, last1[3:0], last1[4]);
      end
      if (v2) begin
        exp2 = q2.pop_front();
        total++;
        if (out_valid2 !== 1'b1 || ex3_2 !== exp2[7:0] || err2 !== exp2[8]) begin
          bad++;
          $display("FAIL b2b2 i=%0d: got v=%b ex3=%h err=%b want v=1 ex3=%h err=%b", i, out_valid2, ex3_2, err2, exp2[7:0], exp2[8]);
        end
      end else begin
        total++;
        if (out_valid2 !== 1'b0) begin
          bad++;
          $display("FAIL b2b2 idle i=%0d: got v=%b want v=0", i, out_valid2);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; bcd1 = '0; bcd2 = '0;
    last1 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_invalid();
    test_two_digit();
    test_hold();
    test_midstream_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
